// File: rtl/mem_stream_reader_if.sv
// rtl/mem_stream_reader_if.sv - valid/ready word stream with last flag
interface mem_stream_reader_if #(
   parameter int width = 32
);
   logic             valid;
   logic [width-1:0] data;
   logic             last;
   logic             ready;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - memory window read sequencer with stream output; MEM_READER_LOOP_EN adds repeating passes
module mem_stream_reader #(
   parameter int width     = 32,
   parameter int length    = 10,
   parameter int addr_size = $clog2(length),
   parameter int cnt_size  = $clog2(length + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [addr_size-1:0] base_addr,
   input  logic [cnt_size-1:0]  count,
   output logic                 busy,
   output logic                 done,
   output logic [addr_size-1:0] r_addr,
   input  logic [width-1:0]     r_data,
   mem_stream_reader_if.master  m
`ifdef MEM_READER_LOOP_EN
   ,
   input  logic                 loop
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(length - 1);
   localparam logic [cnt_size-1:0]  ONE       = cnt_size'(1);

   state_t               state_q, state_d;
   logic [addr_size-1:0] addr_q, addr_d;
   logic [cnt_size-1:0]  remaining_q, remaining_d;
   logic [width-1:0]     data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 done_q, done_d;
`ifdef MEM_READER_LOOP_EN
   logic [addr_size-1:0] base_q, base_d;
   logic [cnt_size-1:0]  count_q, count_d;
`endif

   logic [addr_size-1:0] addr_next;
   logic                 load;
   logic                 last_hs;

   // Next-state and output-register logic for the read sequencer
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      data_d      = data_q;
      valid_d     = valid_q;
      last_d      = last_q;
      done_d      = 1'b0;
`ifdef MEM_READER_LOOP_EN
      base_d      = base_q;
      count_d     = count_q;
`endif
      // Wrap modulo the memory depth, not the power-of-two address range
      addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + addr_size'(1);
      load      = (remaining_q != '0) && (!valid_q || m.ready);
      last_hs   = valid_q && m.ready && last_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  state_d     = RUN;
                  addr_d      = base_addr;
                  remaining_d = count;
`ifdef MEM_READER_LOOP_EN
                  base_d      = base_addr;
                  count_d     = count;
`endif
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (load) begin
               data_d      = r_data;
               valid_d     = 1'b1;
               last_d      = (remaining_q == ONE);
               remaining_d = remaining_q - ONE;
               addr_d      = addr_next;
`ifdef MEM_READER_LOOP_EN
               // Point back at base early so a looped pass can load its first word at the last handshake
               if (remaining_q == ONE) begin
                  addr_d = base_q;
               end
`endif
            end else if (last_hs) begin
`ifdef MEM_READER_LOOP_EN
               if (loop) begin
                  data_d      = r_data;
                  valid_d     = 1'b1;
                  last_d      = (count_q == ONE);
                  remaining_d = count_q - ONE;
                  addr_d      = (count_q == ONE) ? base_q : addr_next;
               end else begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
`else
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end else if (valid_q && m.ready) begin
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef MEM_READER_LOOP_EN
         base_q      <= '0;
         count_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         done_q      <= done_d;
`ifdef MEM_READER_LOOP_EN
         base_q      <= base_d;
         count_q     <= count_d;
`endif
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = done_q;
   assign r_addr  = addr_q;
   assign m.valid = valid_q;
   assign m.data  = data_q;
   assign m.last  = last_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - scoreboard bench for mem_stream_reader
module tb_mem_stream_reader;

   localparam int WIDTH = 32;
   localparam int LEN   = 10;
   localparam int AW    = $clog2(LEN);
   localparam int CW    = $clog2(LEN + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] count = '0;
   logic          busy, done;
   logic [AW-1:0] r_addr;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] mem [LEN];
`ifdef MEM_READER_LOOP_EN
   logic          loop = 1'b0;
`endif

   mem_stream_reader_if #(.width(WIDTH)) m_if ();

   mem_stream_reader #(.width(WIDTH), .length(LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .r_addr    (r_addr),
      .r_data    (r_data),
      .m         (m_if)
`ifdef MEM_READER_LOOP_EN
      ,
      .loop      (loop)
`endif
   );

   always #5 clk = ~clk;

   assign r_data = (int'(r_addr) < LEN) ? mem[r_addr] : '0;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int hs_cnt = 0;
   int last_hs_cnt = 0;
   int done_cnt = 0;
   logic [WIDTH:0] sb [$];

   // Scoreboard: compare every handshaken word against the expected queue
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_if.valid && m_if.ready) begin
            logic [WIDTH:0] exp_w;
            hs_cnt++;
            if (m_if.last) last_hs_cnt++;
            chk_cnt++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected: got last=%0d data=%0d, required no word", m_if.last, m_if.data);
            end else begin
               exp_w = sb.pop_front();
               if ({m_if.last, m_if.data} !== exp_w)
                  $display("FAIL sb_word: got last=%0d data=%0d, required last=%0d data=%0d",
                           m_if.last, m_if.data, exp_w[WIDTH], exp_w[WIDTH-1:0]);
               else pass_cnt++;
            end
         end
         if (done) begin
            done_cnt++;
            chk_cnt++;
            if (m_if.valid !== 1'b0) $display("FAIL done_valid_overlap: m_valid=%0b, required 0", m_if.valid);
            else pass_cnt++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         sb.push_back({(i == n - 1), mem[(base + i) % LEN]});
      end
   endtask

   task automatic start_xfer(input int base, input int n);
      base_addr = AW'(base);
      count     = CW'(n);
      start     = 1'b1;
      cyc();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      chk_cnt++;
      if ({busy, done, m_if.valid, m_if.last} !== 4'b0000 || m_if.data !== '0 || r_addr !== '0)
         $display("FAIL reset_state: busy=%0b done=%0b valid=%0b last=%0b data=%0d r_addr=%0d, required all 0",
                  busy, done, m_if.valid, m_if.last, m_if.data, r_addr);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      m_if.ready = 1'b1;
      push_words(2, 4);
      start_xfer(2, 4);
      chk_cnt++;
      if (m_if.valid !== 1'b0 || busy !== 1'b1)
         $display("FAIL basic_latency: valid=%0b busy=%0b, required 0 1", m_if.valid, busy);
      else pass_cnt++;
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk_cnt++;
         if (m_if.valid !== 1'b1) $display("FAIL basic_gapless[%0d]: valid=%0b, required 1", i, m_if.valid);
         else pass_cnt++;
         cyc();
      end
      chk_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || m_if.valid !== 1'b0)
         $display("FAIL basic_end: done=%0b busy=%0b valid=%0b, required 1 0 0", done, busy, m_if.valid);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (done !== 1'b0 || sb.size() != 0)
         $display("FAIL basic_done_pulse: done=%0b pending=%0d, required 0 0", done, sb.size());
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int d0 = done_cnt;
      int n  = 0;
      m_if.ready = 1'b1;
      push_words(8, 5);
      start_xfer(8, 5);
      while (done !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      chk_cnt++;
      if (done !== 1'b1) $display("FAIL wrap_timeout: done=%0b after %0d cycles, required 1", done, n);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (done_cnt - d0 != 1 || sb.size() != 0)
         $display("FAIL wrap_end: done pulses=%0d pending=%0d, required 1 0", done_cnt - d0, sb.size());
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int h0 = hs_cnt;
      int n  = 0;
      logic pv, pl;
      logic [WIDTH-1:0] pd;
      m_if.ready = 1'b0;
      push_words(5, 3);
      start_xfer(5, 3);
      cyc();
      for (int i = 0; i < 6; i++) begin
         m_if.ready = pat[i];
         pv = m_if.valid;
         pd = m_if.data;
         pl = m_if.last;
         cyc();
         if (pv && !pat[i]) begin
            chk_cnt++;
            if (m_if.data !== pd || m_if.last !== pl || m_if.valid !== 1'b1)
               $display("FAIL bp_stable[%0d]: data=%0d last=%0b, required data=%0d last=%0b", i, m_if.data, m_if.last, pd, pl);
            else pass_cnt++;
         end
      end
      m_if.ready = 1'b1;
      while (busy === 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      cyc();
      chk_cnt++;
      if (hs_cnt - h0 != 3 || sb.size() != 0 || busy !== 1'b0)
         $display("FAIL bp_handshakes: count=%0d pending=%0d busy=%0b, required 3 0 0", hs_cnt - h0, sb.size(), busy);
      else pass_cnt++;
   endtask

   task automatic test_zero_count();
      int d0 = done_cnt;
      m_if.ready = 1'b1;
      start_xfer(3, 0);
      chk_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || m_if.valid !== 1'b0)
         $display("FAIL zero_pulse: done=%0b busy=%0b valid=%0b, required 1 0 0", done, busy, m_if.valid);
      else pass_cnt++;
      cyc();
      cyc();
      chk_cnt++;
      if (done !== 1'b0 || done_cnt - d0 != 1 || m_if.valid !== 1'b0)
         $display("FAIL zero_single: done=%0b pulses=%0d valid=%0b, required 0 1 0", done, done_cnt - d0, m_if.valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int h0 = hs_cnt;
      int d0;
      int n = 0;
      m_if.ready = 1'b1;
      push_words(0, 6);
      start_xfer(0, 6);
      cyc();
      cyc();
      cyc();
      chk_cnt++;
      if (hs_cnt - h0 != 2) $display("FAIL rst_pre_words: count=%0d, required 2", hs_cnt - h0);
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (m_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL rst_async: valid=%0b busy=%0b done=%0b, required 0 0 0", m_if.valid, busy, done);
      else pass_cnt++;
      sb.delete();
      d0 = done_cnt;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk_cnt++;
      if (done_cnt != d0 || done !== 1'b0) $display("FAIL rst_no_done: pulses=%0d, required 0", done_cnt - d0);
      else pass_cnt++;
      push_words(0, 1);
      start_xfer(0, 1);
      while (done !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk_cnt++;
      if (done !== 1'b1 || sb.size() != 0)
         $display("FAIL rst_restart: done=%0b pending=%0d, required 1 0", done, sb.size());
      else pass_cnt++;
      cyc();
   endtask

`ifdef MEM_READER_LOOP_EN
   task automatic test_loop();
      int h0 = hs_cnt;
      int l0 = last_hs_cnt;
      int d0 = done_cnt;
      m_if.ready = 1'b1;
      loop = 1'b1;
      for (int p = 0; p < 3; p++) push_words(0, 2);
      start_xfer(0, 2);
      cyc();
      for (int k = 0; k < 6; k++) begin
         chk_cnt++;
         if (m_if.valid !== 1'b1 || done !== 1'b0)
            $display("FAIL loop_gapless[%0d]: valid=%0b done=%0b, required 1 0", k, m_if.valid, done);
         else pass_cnt++;
         if (last_hs_cnt - l0 >= 2) loop = 1'b0;
         cyc();
      end
      chk_cnt++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL loop_end: done=%0b busy=%0b, required 1 0", done, busy);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (done_cnt - d0 != 1 || hs_cnt - h0 != 6 || sb.size() != 0)
         $display("FAIL loop_totals: pulses=%0d words=%0d pending=%0d, required 1 6 0", done_cnt - d0, hs_cnt - h0, sb.size());
      else pass_cnt++;
   endtask
`endif

   initial begin
      for (int i = 0; i < LEN; i++) mem[i] = WIDTH'(i + 100);
      m_if.ready = 1'b0;
      #2;
      test_reset();
      cyc();
      rst_n = 1'b1;
      cyc();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_count();
      test_reset_mid();
`ifdef MEM_READER_LOOP_EN
      test_loop();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
